// File: rtl/image_loader.sv
// -----------------------------------------------------------------------------
// image_loader
//   Frame buffer that feeds one image, pixel by pixel, into conv1_layer.
//   Pixels are written randomly while idle; a start request then streams the
//   whole frame out in address order, one pixel per clock, with no gaps.
//
// Ports
//   clk        single clock, all state updated on the rising edge
//   rst_n      asynchronous active-low reset (memory contents are kept)
//   wr_en      pixel write strobe
//   wr_addr    pixel write address
//   wr_data    pixel write data
//   start      begin streaming one frame (ignored while a frame is running)
//   data_out   pixel stream, forced to 0 whenever valid_out is low
//   valid_out  data_out carries a frame pixel
//   busy       frame streaming in progress
//   done       one-cycle end-of-frame pulse
//   wr_err     one-cycle pulse after a rejected write
//   frame_cnt  completed-frame count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module image_loader #(
    parameter int IMG_PIXELS = 784,
    parameter int DATA_BITS  = 8,
    parameter int ADDR_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 start,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err,
    output logic [7:0]           frame_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(IMG_PIXELS - 1);
    // One extra bit so the bound compare also works when IMG_PIXELS == 2**ADDR_BITS.
    localparam logic [ADDR_BITS:0]   PIX_LIMIT = (ADDR_BITS + 1)'(IMG_PIXELS);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 wr_err_q, wr_err_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;

    logic [DATA_BITS-1:0] mem [IMG_PIXELS];
    logic [DATA_BITS-1:0] rd_data_q;

    logic wr_legal;
    logic wr_accept;

    assign wr_legal  = ({1'b0, wr_addr} < PIX_LIMIT);
    assign wr_accept = wr_en && wr_legal && (state_q == IDLE);

    // Pixel store: no reset so it maps onto block RAM and survives rst_n.
    // Read-during-write returns the old word, but the stream reads address 0
    // one edge after start, so a write issued with start is already visible.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[idx_q];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        // valid follows the state by one edge, matching the RAM read latency.
        valid_d     = (state_q == STREAM);
        // The only cycle with valid high in IDLE is the one carrying the last
        // pixel, so done lands on the cycle right after it.
        done_d      = valid_q && (state_q == IDLE);
        wr_err_d    = wr_en && (!wr_legal || (state_q == STREAM));
        frame_cnt_d = frame_cnt_q + 8'(done_d);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                // Leaving on the last read puts IDLE one edge early, so a held
                // start relaunches on the same edge that raises done.
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            wr_err_q    <= wr_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign data_out  = valid_q ? rd_data_q : '0;
    assign valid_out = valid_q;
    // Covers the tail cycle carrying the last pixel; held low during done even
    // when a back-to-back frame has already been launched.
    assign busy      = ((state_q == STREAM) || valid_q) && !done_q;
    assign done      = done_q;
    assign wr_err    = wr_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;

    localparam int NPIX = 784;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [7:0] data_out;
    logic       valid_out;
    logic       busy;
    logic       done;
    logic       wr_err;
    logic [7:0] frame_cnt;

    image_loader #(.IMG_PIXELS(NPIX), .DATA_BITS(8), .ADDR_BITS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done),
        .wr_err    (wr_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;
    int werr_cnt  = 0;

    logic [7:0] model_mem [NPIX];
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor on the falling edge: pops the scoreboard for every valid pixel.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_out) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL extra_pixel observed=%0h expected=none", data_out);
                end else begin
                    logic [7:0] exp_px;
                    exp_px = sb.pop_front();
                    check("pixel", {24'd0, data_out}, {24'd0, exp_px});
                end
            end else begin
                check("idle_data_zero", {24'd0, data_out}, 32'd0);
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
            if (wr_err) werr_cnt++;
        end
    end

    task automatic push_frame();
        for (int k = 0; k < NPIX; k++) sb.push_back(model_mem[k]);
    endtask

    task automatic start_frame();
        start = 1'b1;
        push_frame();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    int n, v0, d0, w0;
    logic [7:0] f0;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        tick(); tick();
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, wr_err}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Load pixel[k] = k mod 256
        for (int k = 0; k < NPIX; k++) begin
            wr_en = 1'b1; wr_addr = 10'(k); wr_data = 8'(k);
            model_mem[k] = 8'(k);
            tick();
        end
        wr_en = 1'b0;
        tick(); tick();
        check("load_no_wr_err", werr_cnt, 0);
        $display("load: %0d pixels written", NPIX);

        // Frame 1
        v0 = valid_cnt; d0 = done_cnt;
        start_frame();
        check("f1_busy_after_start", {31'd0, busy}, 32'd1);
        check("f1_valid_after_start", {31'd0, valid_out}, 32'd0);
        wait_done(n);
        check("f1_latency", n, 785);
        check("f1_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        check("f1_valid_at_done", {31'd0, valid_out}, 32'd0);
        tick();
        check("f1_done_one_cycle", {31'd0, done}, 32'd0);
        check("f1_valid_count", valid_cnt - v0, NPIX);
        check("f1_done_count", done_cnt - d0, 1);
        check("f1_sb_empty", sb.size(), 0);
        $display("frame1: latency=%0d frame_cnt=%0d", n, frame_cnt);

        // Rejected writes: out of range, then during STREAM
        w0 = werr_cnt;
        wr_en = 1'b1; wr_addr = 10'd784; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        check("werr_oob", {31'd0, wr_err}, 32'd1);
        tick();
        check("werr_oob_pulse", {31'd0, wr_err}, 32'd0);
        start_frame();
        repeat (10) tick();
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        check("werr_stream", {31'd0, wr_err}, 32'd1);
        tick();
        check("werr_stream_pulse", {31'd0, wr_err}, 32'd0);
        wait_done(n);
        tick();
        check("werr_count", werr_cnt - w0, 2);
        check("f2_frame_cnt", {24'd0, frame_cnt}, 32'd2);
        $display("rejected writes: wr_err pulses=%0d", werr_cnt - w0);

        // Restart mid-frame is ignored; also re-checks pixel[5] unchanged
        v0 = valid_cnt; d0 = done_cnt;
        start_frame();
        repeat (299) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("restart_latency", n, 485);
        tick();
        check("restart_valid_count", valid_cnt - v0, NPIX);
        check("restart_done_count", done_cnt - d0, 1);
        check("restart_sb_empty", sb.size(), 0);
        $display("mid-frame start: remaining=%0d valid=%0d", n, valid_cnt - v0);

        // start held for three back-to-back frames
        v0 = valid_cnt; d0 = done_cnt; f0 = frame_cnt;
        start = 1'b1;
        push_frame(); push_frame(); push_frame();
        tick();
        repeat (1570) tick();
        check("b2b_gap_cycle", {30'd0, done, valid_out}, 32'd2);
        start = 1'b0;
        tick();
        wait_done(n);
        check("b2b_latency", n, 784);
        check("b2b_frame_cnt", {24'd0, frame_cnt}, {24'd0, 8'(f0 + 8'd3)});
        tick();
        check("b2b_valid_count", valid_cnt - v0, 3 * NPIX);
        check("b2b_done_count", done_cnt - d0, 3);
        check("b2b_sb_empty", sb.size(), 0);
        $display("back-to-back: valid=%0d done=%0d", valid_cnt - v0, done_cnt - d0);

        // Reset in the middle of a frame
        d0 = done_cnt;
        start_frame();
        repeat (400) tick();
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, valid_out}, 32'd0);
        check("abort_data", {24'd0, data_out}, 32'd0);
        check("abort_busy_done_err", {29'd0, busy, done, wr_err}, 32'd0);
        check("abort_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        sb.delete();
        tick(); tick();
        check("abort_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        tick();
        start_frame();
        wait_done(n);
        check("post_rst_latency", n, 785);
        check("post_rst_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        tick();
        check("post_rst_sb_empty", sb.size(), 0);
        $display("reset abort: post-reset frame latency=%0d", n);

        // Write and start in the same cycle
        wr_en = 1'b1; wr_addr = 10'd0; wr_data = 8'hAA;
        model_mem[0] = 8'hAA;
        start = 1'b1;
        push_frame();
        tick();
        wr_en = 1'b0; start = 1'b0;
        check("combo_no_wr_err", {31'd0, wr_err}, 32'd0);
        wait_done(n);
        check("combo_latency", n, 785);
        tick();
        check("combo_sb_empty", sb.size(), 0);
        $display("write+start: first pixel expected 0xAA, latency=%0d", n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
